// File: rtl/ble_pkg.sv
// Shared BLE link-layer constants, receiver state encoding and the CRC-24 step
// used by both the RX deframer and the TX-side CRC generator.
package ble_pkg;

  localparam logic [31:0] ADV_ACCESS_ADDR  = 32'h8E89BED6;
  localparam logic [23:0] ADV_CRC_INIT     = 24'h555555;
  localparam logic [23:0] CRC24_POLY       = 24'h00065B;
  localparam logic [7:0]  PREAMBLE_AA_LSB0 = 8'hAA;
  localparam logic [7:0]  PREAMBLE_AA_LSB1 = 8'h55;
  localparam int          WHITEN_TAP       = 4;

  typedef enum logic [1:0] {
    HUNT,
    HEADER,
    PAYLOAD,
    CRC
  } rx_state_t;

  // The preamble alternates starting with the same bit value as AA[0].
  function automatic logic [7:0] preamble_for(input logic [31:0] aa);
    return aa[0] ? PREAMBLE_AA_LSB1 : PREAMBLE_AA_LSB0;
  endfunction

  function automatic logic [23:0] crc24_step(input logic [23:0] crc, input logic d);
    logic fb;
    fb = crc[23] ^ d;
    return {crc[22:0], 1'b0} ^ (fb ? CRC24_POLY : 24'h000000);
  endfunction

endpackage

// File: rtl/ble_crc24.sv
// Serial BLE CRC-24 LFSR. 'zero' reports whether the register will hold an
// all-zero residue after this cycle's update, so a receiver can flag it in step.
module ble_crc24
  import ble_pkg::*;
#(
  parameter logic [23:0] SEED = ADV_CRC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [23:0] crc,
  output logic        zero
);

  logic [23:0] crc_reg;
  logic [23:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (init) begin
      crc_next = SEED;
    end else if (en) begin
      crc_next = crc24_step(crc_reg, din);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= '0;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc  = crc_reg;
  assign zero = (crc_next == 24'h000000);

endmodule

// File: rtl/ble_packet_rx.sv
// BLE link-layer receive deframer: preamble/AA hunt, header capture, payload
// bytes and CRC-24 check. Define BLE_DEWHITEN_EN to compile in dewhitening.
module ble_packet_rx
  import ble_pkg::*;
#(
  parameter logic [31:0] ACCESS_ADDR = ADV_ACCESS_ADDR,
  parameter logic [23:0] CRC_INIT    = ADV_CRC_INIT,
  parameter int          MAX_LEN     = 37
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic [5:0]  chan_idx,
  output logic        sync_det,
  output logic [15:0] hdr,
  output logic        hdr_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        pkt_err,
  output logic        busy
);

  localparam logic [7:0] PREAMBLE  = preamble_for(ACCESS_ADDR);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_t   state_reg, state_next;
  logic [39:0] sr_reg, sr_next, sr_shift;
  logic [4:0]  bit_cnt_reg, bit_cnt_next, bit_cnt_inc;
  logic [7:0]  byte_cnt_reg, byte_cnt_next;
  logic [15:0] data_sr_reg, data_sr_next, data_shift;
  logic [15:0] hdr_reg, hdr_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        crc_ok_reg, crc_ok_next;
  logic        sync_det_reg, sync_det_next;
  logic        hdr_valid_reg, hdr_valid_next;
  logic        rx_byte_valid_reg, rx_byte_valid_next;
  logic        pkt_done_reg, pkt_done_next;
  logic        pkt_err_reg, pkt_err_next;

  logic        sync_hit;
  logic        pdu_bit;
  logic        d;
  logic        crc_zero;
  logic [23:0] crc_unused;

  assign pdu_bit  = bit_valid && (state_reg != HUNT);
  assign sr_shift = {bit_in, sr_reg[39:1]};
  assign sync_hit = bit_valid && (state_reg == HUNT) &&
                    (sr_shift[39:8] == ACCESS_ADDR) && (sr_shift[7:0] == PREAMBLE);

`ifdef BLE_DEWHITEN_EN
  logic [6:0] w_reg, w_next;

  assign d = bit_in ^ w_reg[6];

  // Seed puts chan_idx[0] in w[6] down to chan_idx[5] in w[1], with w[0] fixed at 1.
  always_comb begin
    w_next = w_reg;
    if (sync_hit) begin
      w_next = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3],
                chan_idx[4], chan_idx[5], 1'b1};
    end else if (pdu_bit) begin
      w_next = {w_reg[5:0], w_reg[6]};
      w_next[WHITEN_TAP] = w_reg[WHITEN_TAP-1] ^ w_reg[6];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg <= '0;
    end else begin
      w_reg <= w_next;
    end
  end
`else
  logic unused_chan;
  assign unused_chan = ^chan_idx;
  assign d = bit_in;
`endif

  ble_crc24 #(
    .SEED (CRC_INIT)
  ) u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (sync_hit),
    .en    (pdu_bit),
    .din   (d),
    .crc   (crc_unused),
    .zero  (crc_zero)
  );

  // Header and payload share one right-shifting assembler; a byte lands in [15:8].
  assign data_shift  = {d, data_sr_reg[15:1]};
  assign bit_cnt_inc = (bit_cnt_reg == 5'd31) ? bit_cnt_reg : bit_cnt_reg + 5'd1;

  always_comb begin
    state_next         = state_reg;
    sr_next            = sr_reg;
    bit_cnt_next       = bit_cnt_reg;
    byte_cnt_next      = byte_cnt_reg;
    data_sr_next       = data_sr_reg;
    hdr_next           = hdr_reg;
    rx_byte_next       = rx_byte_reg;
    crc_ok_next        = crc_ok_reg;
    sync_det_next      = 1'b0;
    hdr_valid_next     = 1'b0;
    rx_byte_valid_next = 1'b0;
    pkt_done_next      = 1'b0;
    pkt_err_next       = 1'b0;

    if (bit_valid) begin
      sr_next = sr_shift;
    end

    case (state_reg)
      HUNT: begin
        if (sync_hit) begin
          sync_det_next = 1'b1;
          sr_next       = '0;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          state_next    = HEADER;
        end
      end
      HEADER: begin
        if (bit_valid) begin
          data_sr_next = data_shift;
          if (bit_cnt_reg == 5'd15) begin
            hdr_next       = data_shift;
            hdr_valid_next = 1'b1;
            bit_cnt_next   = '0;
            byte_cnt_next  = '0;
            if (data_shift[15:8] > MAX_LEN_B) begin
              pkt_err_next = 1'b1;
              state_next   = HUNT;
            end else if (data_shift[15:8] == 8'd0) begin
              state_next = CRC;
            end else begin
              state_next = PAYLOAD;
            end
          end else begin
            bit_cnt_next = bit_cnt_inc;
          end
        end
      end
      PAYLOAD: begin
        if (bit_valid) begin
          data_sr_next = data_shift;
          if (bit_cnt_reg == 5'd7) begin
            rx_byte_next       = data_shift[15:8];
            rx_byte_valid_next = 1'b1;
            bit_cnt_next       = '0;
            // hdr_reg[15:8] is the length latched at the end of the header.
            if (byte_cnt_reg == hdr_reg[15:8] - 8'd1) begin
              byte_cnt_next = '0;
              state_next    = CRC;
            end else begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
          end else begin
            bit_cnt_next = bit_cnt_inc;
          end
        end
      end
      CRC: begin
        if (bit_valid) begin
          if (bit_cnt_reg == 5'd23) begin
            pkt_done_next = 1'b1;
            crc_ok_next   = crc_zero;
            bit_cnt_next  = '0;
            state_next    = HUNT;
          end else begin
            bit_cnt_next = bit_cnt_inc;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= HUNT;
      sr_reg            <= '0;
      bit_cnt_reg       <= '0;
      byte_cnt_reg      <= '0;
      data_sr_reg       <= '0;
      hdr_reg           <= '0;
      rx_byte_reg       <= '0;
      crc_ok_reg        <= 1'b0;
      sync_det_reg      <= 1'b0;
      hdr_valid_reg     <= 1'b0;
      rx_byte_valid_reg <= 1'b0;
      pkt_done_reg      <= 1'b0;
      pkt_err_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sr_reg            <= sr_next;
      bit_cnt_reg       <= bit_cnt_next;
      byte_cnt_reg      <= byte_cnt_next;
      data_sr_reg       <= data_sr_next;
      hdr_reg           <= hdr_next;
      rx_byte_reg       <= rx_byte_next;
      crc_ok_reg        <= crc_ok_next;
      sync_det_reg      <= sync_det_next;
      hdr_valid_reg     <= hdr_valid_next;
      rx_byte_valid_reg <= rx_byte_valid_next;
      pkt_done_reg      <= pkt_done_next;
      pkt_err_reg       <= pkt_err_next;
    end
  end

  assign sync_det      = sync_det_reg;
  assign hdr           = hdr_reg;
  assign hdr_valid     = hdr_valid_reg;
  assign rx_byte       = rx_byte_reg;
  assign rx_byte_valid = rx_byte_valid_reg;
  assign pkt_done      = pkt_done_reg;
  assign crc_ok        = crc_ok_reg;
  assign pkt_err       = pkt_err_reg;
  assign busy          = (state_reg != HUNT);

endmodule

// File: tb/tb_ble_packet_rx.sv
// Scoreboard bench for ble_packet_rx: packets are built and optionally whitened
// here, expected events are queued before driving, and a monitor pops them.
module tb_ble_packet_rx;

  localparam logic [31:0] AA        = 32'h8E89BED6;
  localparam logic [7:0]  PRE       = 8'hAA;
  localparam logic [23:0] INIT      = 24'h555555;
  localparam int          MAX_LEN   = 37;
`ifdef BLE_DEWHITEN_EN
  localparam bit          DEWHITEN  = 1'b1;
`else
  localparam bit          DEWHITEN  = 1'b0;
`endif

  localparam int EV_SYNC = 1;
  localparam int EV_HDR  = 2;
  localparam int EV_BYTE = 3;
  localparam int EV_ERR  = 4;
  localparam int EV_DONE = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic [5:0]  chan_idx;
  logic        sync_det;
  logic [15:0] hdr;
  logic        hdr_valid;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        pkt_done;
  logic        crc_ok;
  logic        pkt_err;
  logic        busy;

  always #5 clk = ~clk;

  ble_packet_rx dut (
    .clk           (clk),
    .reset         (reset),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .chan_idx      (chan_idx),
    .sync_det      (sync_det),
    .hdr           (hdr),
    .hdr_valid     (hdr_valid),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .pkt_done      (pkt_done),
    .crc_ok        (crc_ok),
    .pkt_err       (pkt_err),
    .busy          (busy)
  );

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t sb[$];
  bit  air[$];
  bit  wseq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", kind, 0);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (sync_det === 1'b1)      observe(EV_SYNC, 16'h0);
    if (hdr_valid === 1'b1)     observe(EV_HDR, hdr);
    if (rx_byte_valid === 1'b1) observe(EV_BYTE, {8'h00, rx_byte});
    if (pkt_err === 1'b1)       observe(EV_ERR, 16'h0);
    if (pkt_done === 1'b1)      observe(EV_DONE, {15'h0, crc_ok});
  end

  function automatic logic [23:0] crc_step(input logic [23:0] c, input bit db);
    logic fb;
    fb = c[23] ^ db;
    return {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
  endfunction

  task automatic make_wseq(input logic [5:0] ch, input int n);
    logic [6:0] w;
    logic [6:0] nw;
    wseq.delete();
    w[0] = 1'b1;
    for (int k = 1; k < 7; k++) w[k] = ch[6-k];
    for (int i = 0; i < n; i++) begin
      wseq.push_back(w[6]);
      nw    = {w[5:0], w[6]};
      nw[4] = nw[4] ^ w[6];
      w     = nw;
    end
  endtask

  // Air bits after the AA: header, nbytes of 0x11,0x22,.., then CRC MSB first.
  task automatic build(input logic [15:0] h, input int nbytes, input int flip,
                       input bit whiten, input logic [5:0] ch);
    logic [23:0] c;
    logic [7:0]  b;
    air.delete();
    for (int i = 0; i < 16; i++) air.push_back(h[i]);
    for (int j = 0; j < nbytes; j++) begin
      b = 8'((j + 1) * 17);
      for (int i = 0; i < 8; i++) air.push_back(b[i]);
    end
    c = INIT;
    for (int i = 0; i < air.size(); i++) c = crc_step(c, air[i]);
    for (int j = 23; j >= 0; j--) air.push_back(c[j]);
    if (flip >= 0) air[flip] = !air[flip];
    if (whiten) begin
      make_wseq(ch, air.size());
      for (int i = 0; i < air.size(); i++) air[i] = air[i] ^ wseq[i];
    end
  endtask

  // Expected events when only the first n air bits are delivered.
  task automatic predict(input int n, input logic [5:0] ch);
    bit          d[$];
    logic [15:0] h;
    logic [7:0]  b;
    logic [23:0] c;
    int          len;
    bit          ok;
    make_wseq(ch, n);
    for (int i = 0; i < n; i++) d.push_back(air[i] ^ (DEWHITEN ? wseq[i] : 1'b0));
    expect_ev(EV_SYNC, 16'h0);
    if (n < 16) return;
    for (int i = 0; i < 16; i++) h[i] = d[i];
    expect_ev(EV_HDR, h);
    len = int'(h[15:8]);
    if (len > MAX_LEN) begin
      expect_ev(EV_ERR, 16'h0);
      return;
    end
    for (int bi = 0; bi < len; bi++) begin
      if (16 + 8 * bi + 8 <= n) begin
        for (int i = 0; i < 8; i++) b[i] = d[16 + 8 * bi + i];
        expect_ev(EV_BYTE, {8'h00, b});
      end
    end
    if (16 + 8 * len + 24 <= n) begin
      c = INIT;
      for (int i = 0; i < 16 + 8 * len; i++) c = crc_step(c, d[i]);
      ok = 1'b1;
      for (int j = 0; j < 24; j++) if (d[16 + 8 * len + j] != c[23-j]) ok = 1'b0;
      expect_ev(EV_DONE, {15'h0, ok});
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit b, input int gap);
    idle(gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_frame(input int n, input int maxgap);
    int g;
    for (int i = 0; i < 40 + n; i++) begin
      g = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
      if (i < 8)       send_bit(PRE[i], g);
      else if (i < 40) send_bit(AA[i-8], g);
      else             send_bit(air[i-40], g);
    end
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    chan_idx  = 6'd0;
    idle(2);
    check("rst_sync_det", sync_det, 0);
    check("rst_hdr", hdr, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_rx_byte_valid", rx_byte_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(1);

    // Good packet, back-to-back bits
    build(16'h0602, 6, -1, 1'b0, 6'd0);
    predict(air.size(), 6'd0);
    send_frame(air.size(), 0);
    check("good_done_latency", pkt_done, 1);
    check("good_crc_ok", crc_ok, 1);
    idle(3);
    check("good_crc_ok_held", crc_ok, 1);
    check("good_hdr_held", hdr, 16'h0602);
    check("good_busy_idle", busy, 0);
    drain("good_drain");
    $display("pkt good: hdr=%h crc_ok=%0b", hdr, crc_ok);

    // Flipped payload bit
    build(16'h0602, 6, 16 + 8 * 2 + 3, 1'b0, 6'd0);
    predict(air.size(), 6'd0);
    send_frame(air.size(), 0);
    check("badcrc_done", pkt_done, 1);
    check("badcrc_crc_ok", crc_ok, 0);
    drain("badcrc_drain");
    $display("pkt bad_crc: hdr=%h crc_ok=%0b", hdr, crc_ok);

    // Length above MAX_LEN
    build(16'h2602, 2, -1, 1'b0, 6'd0);
    predict(air.size(), 6'd0);
    send_frame(air.size(), 0);
    check("len38_no_done", pkt_done, 0);
    check("len38_busy", busy, 0);
    drain("len38_drain");
    $display("pkt len38: hdr=%h busy=%0b", hdr, busy);

    // Zero-length payload
    build(16'h0003, 0, -1, 1'b0, 6'd0);
    predict(air.size(), 6'd0);
    send_frame(air.size(), 0);
    check("len0_done", pkt_done, 1);
    check("len0_crc_ok", crc_ok, 1);
    drain("len0_drain");
    $display("pkt len0: hdr=%h crc_ok=%0b", hdr, crc_ok);

    // Random strobe gaps
    build(16'h0602, 6, -1, 1'b0, 6'd0);
    predict(air.size(), 6'd0);
    send_frame(air.size(), 5);
    check("gaps_done", pkt_done, 1);
    check("gaps_crc_ok", crc_ok, 1);
    drain("gaps_drain");
    $display("pkt gaps: hdr=%h crc_ok=%0b", hdr, crc_ok);

    // Reset in the middle of the payload, then a clean packet
    build(16'h0602, 6, -1, 1'b0, 6'd0);
    predict(35, 6'd0);
    send_frame(35, 0);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    idle(2);
    check("midrst_busy", busy, 0);
    check("midrst_no_done", pkt_done, 0);
    reset = 1'b0;
    idle(1);
    drain("midrst_drain");
    predict(air.size(), 6'd0);
    send_frame(air.size(), 0);
    check("after_rst_crc_ok", crc_ok, 1);
    drain("after_rst_drain");
    $display("pkt after_reset: hdr=%h crc_ok=%0b", hdr, crc_ok);

    // Whitened stimulus on channel 37
    chan_idx = 6'd37;
    build(16'h0602, 6, -1, 1'b1, 6'd37);
    predict(air.size(), 6'd37);
    send_frame(air.size(), 0);
`ifdef BLE_DEWHITEN_EN
    check("whiten_done", pkt_done, 1);
    check("whiten_crc_ok", crc_ok, 1);
`endif
    drain("whiten_drain");
    $display("pkt whitened ch37: hdr=%h crc_ok=%0b", hdr, crc_ok);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ble_packet_rx.md
Name: ble_packet_rx

Overview:
- Receive-side deframer for the BLE link-layer bitstream produced by the FSK modulator's packet source.
- Takes demodulated, LSB-first serial bits with a per-bit strobe and hunts for preamble + access address.
- Captures the 16-bit PDU header, then emits payload bytes, then checks the 24-bit CRC.
- Sits between the FSK demodulator/bit slicer and the link-layer controller.

Parameters:
- ACCESS_ADDR, 32'h8E89BED6, access address to match (advertising AA by default).
- CRC_INIT, 24'h555555, CRC-24 LFSR seed.
- MAX_LEN, 37, largest accepted payload length in bytes (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  demodulated bit, LSB-first air order.
- bit_valid  in  1  one-cycle strobe; bit_in is sampled only when high.
- chan_idx  in  6  RF channel index, used only when dewhitening is compiled in.
- sync_det  out  1  one-cycle pulse when preamble+AA matches.
- hdr  out  16  captured PDU header; hdr[15:8] is the length.
- hdr_valid  out  1  one-cycle pulse when hdr is updated.
- rx_byte  out  8  payload byte, LSB received first.
- rx_byte_valid  out  1  one-cycle pulse per payload byte.
- pkt_done  out  1  one-cycle pulse at the end of the CRC field.
- crc_ok  out  1  valid with pkt_done; held until the next pkt_done.
- pkt_err  out  1  one-cycle pulse when a length exceeds MAX_LEN.
- busy  out  1  high in every state except HUNT.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high.
  - On reset: state=HUNT; all outputs 0 (hdr=0, rx_byte=0, crc_ok=0); 40-bit shift register and all counters cleared.
  - Reset asserted mid-packet abandons the packet with no pkt_done or pkt_err.
- Shift register:
  - sr[39:0] shifts right on each bit_valid; the new bit enters sr[39].
  - Sync condition: sr[39:8]==ACCESS_ADDR AND sr[7:0]==PREAMBLE, where PREAMBLE = ACCESS_ADDR[0] ? 8'h55 : 8'hAA.
- State machine:
  - HUNT: on the bit_valid that completes the sync condition, pulse sync_det the next cycle. Then clear sr, seed CRC with CRC_INIT, seed whitener, and go to HEADER. Sync matches in any other state are ignored.
  - HEADER: collect 16 bits. After the 16th, register hdr and pulse hdr_valid. Then:
    - length > MAX_LEN: pulse pkt_err and go to HUNT.
    - length==0: go to CRC.
    - otherwise: go to PAYLOAD.
  - PAYLOAD: assemble bytes LSB-first. Each 8th bit updates rx_byte and pulses rx_byte_valid one cycle after the bit's strobe. After `length` bytes, go to CRC.
  - CRC: clock 24 received bits through the same LFSR. After the 24th, pulse pkt_done, set crc_ok = (residue==0), and go to HUNT the same cycle.
- CRC LFSR:
  - Applied to header, payload, and CRC bits: fb = crc[23]^d; crc = {crc[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
  - CRC is transmitted crc[23] first, so a good packet leaves residue 0.
- Timing:
  - All pulses are registered, one cycle after the qualifying bit_valid.
  - bit_valid low holds all state.
  - bit_valid may be asserted on back-to-back cycles (one bit per clk).
- Bit counters saturate safely. The byte counter is 8 bits, so length 255 is reachable when MAX_LEN=255.

Optional Feature:
- Macro: BLE_DEWHITEN_EN.
- Defined:
  - A 7-bit whitening LFSR (x^7+x^4+1) is seeded at sync with w[0]=1 and w[6:1]=chan_idx[0..5] (chan_idx[5] in w[1]). chan_idx is sampled at sync.
  - Each header, payload, and CRC bit is XORed with w[6] before CRC and assembly. Step: w = {w[5:0],w[6]} with w[4] ^= w[6].
- Undefined: bits are used raw, chan_idx is unused, and no whitening logic is present.

Decomposition:
- Shared package ble_pkg holds:
  - ADV_ACCESS_ADDR (32'h8E89BED6), ADV_CRC_INIT (24'h555555), CRC24_POLY (24'h00065B).
  - PREAMBLE_AA_LSB0 (8'hAA), PREAMBLE_AA_LSB1 (8'h55).
  - WHITEN_TAP (4).
  - The state enum {HUNT, HEADER, PAYLOAD, CRC}.
- One sub-module, ble_crc24: serial LFSR with init, en, din, and a zero-residue flag. It is reused by the TX-side CRC generator.

Test Plan:
- Reset values: assert reset for 2 cycles → all outputs 0, busy=0.
- Good packet:
  - Stimulus: preamble 0xAA + AA 0x8E89BED6 + header 16'h0602 + 6 payload bytes 0x11..0x66 + correct CRC, bits back-to-back.
  - Response: sync_det once; hdr=16'h0602 with hdr_valid; 6 rx_byte_valid pulses (0x11..0x66 in order); pkt_done with crc_ok=1.
- Bad CRC: same packet with one payload bit flipped → pkt_done with crc_ok=0, payload bytes still emitted.
- Length checks:
  - Header length 38 with MAX_LEN=37 → pkt_err pulse after the 16th header bit, busy=0, no pkt_done.
  - Header length 0 → hdr_valid, no rx_byte_valid, pkt_done with crc_ok=1 after 24 CRC bits.
- Strobe gaps and reset:
  - Random 0-5 cycle gaps in bit_valid → identical outputs to the back-to-back run.
  - reset during PAYLOAD → HUNT, no pkt_done; the next good packet is received correctly.
- Dewhitening: with BLE_DEWHITEN_EN, chan_idx=37, stimulus whitened by the bench model → same bytes and crc_ok=1. Without the macro, the same stimulus gives crc_ok=0.
